pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the MIPS core, the successor to the plain PC register. It owns the PC register and computes next-PC internally from sequential, branch, jump and register-jump sources. It also handles stall, trap redirect and misaligned-target trapping, and holds an optional return-address stack (RAS) that serves `jr $ra` returns without the register-file read.

## Interface
Parameters:
- `WIDTH`, 32: PC width; legal range 32..64.
- `RESET_PC`, 0: PC value loaded on reset.
- `TRAP_PC`, 32'h0000_0080: redirect target for trap and misalign; zero-extended to `WIDTH`.
- `RAS_DEPTH`, 4: RAS entries; power of two, at least 2.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `pc_wre` in 1: PC write enable; 0 = stall.
- `pc_src` in 2: next-PC source; SEQ=0, BR=1, J=2, JR=3.
- `branch_taken` in 1: qualifies BR.
- `imm` in 16: branch offset, in words.
- `jaddr` in 26: J-type target field.
- `rs_val` in WIDTH: register jump target.
- `link` in 1: jal/jalr; push `pc_plus4` onto the RAS.
- `ret` in 1: JR is a return; pop the RAS.
- `trap` in 1: exception request.
- `cur_pc` out WIDTH: current PC, registered.
- `pc_plus4` out WIDTH: `cur_pc + 4`, combinational.
- `misalign` out 1: one-cycle registered pulse.
- `ras_empty` out 1: RAS count is 0.
- `ras_underflow` out 1: one-cycle registered pulse.

## Operation
Candidate target, chosen by `pc_src`:
- SEQ: `pc_plus4`.
- BR: `pc_plus4 + (sext(imm) << 2)` when `branch_taken`, else `pc_plus4`. Arithmetic is modulo 2^WIDTH.
- J: `{pc_plus4[WIDTH-1:28], jaddr, 2'b00}`.
- JR: RAS top when `ret` is set and the RAS is not empty; otherwise `rs_val`.

Priority on an enabled edge (`pc_wre`=1):
- `trap` first: load `TRAP_PC`.
- Then a misaligned target (target[1:0] != 0): load `TRAP_PC` and pulse `misalign`.
- Otherwise load the target.

RAS behaviour:
- Circular buffer with a top pointer and a count saturating at `RAS_DEPTH`.
- Push (`link`): write `pc_plus4`, advance top, increment count. When full, the oldest entry is overwritten and count stays `RAS_DEPTH`.
- Pop (`ret` with `pc_src`=JR): the target reads the top entry, then top retreats and count decrements.
- Pop when empty: `rs_val` is used and `ras_underflow` pulses. Count stays 0.
- Push and pop in the same cycle: the top entry is replaced with `pc_plus4`; pointer and count are unchanged.
- RAS operations occur only when `pc_wre`=1 and `trap`=0.
- A misaligned return still pops.
- `link` with `pc_src`≠JR pushes only; `ret` with `pc_src`≠JR is ignored.

## Timing
- Reset on the first rising edge with `reset`=0:
  - `cur_pc`=`RESET_PC`, `misalign`=0, `ras_underflow`=0.
  - RAS count=0, so `ras_empty`=1. Entry contents are don't-care.
- Reset takes precedence over every other input. Reset mid-stream discards RAS contents.
- Next-PC latency is 1 cycle: inputs sampled at edge N drive `cur_pc` after edge N.
- `pc_wre`=0: `cur_pc` and the RAS hold, and both pulse outputs are 0 on the next cycle.
- Pulses last exactly one cycle, following the edge that caused them.
- `ras_empty` is derived from the registered count.

## Configuration
- `PC_RAS_EN` defined: RAS present as described.
- Not defined:
  - No RAS storage.
  - `link` and `ret` are ignored; JR always uses `rs_val`.
  - `ras_empty` is tied to 1 and `ras_underflow` to 0.
  - All other behaviour is identical.

## Structure
- Shared package `pc_pkg` holds:
  - the `pc_src_t` enum (SEQ/BR/J/JR);
  - `PC_INC`=4;
  - the default `TRAP_PC`.
- Sub-module `pc_ras`, parameters `WIDTH` and `RAS_DEPTH`: push/pop/top/count/empty/underflow. It is instantiated only under `PC_RAS_EN`.

## Test plan
- Reset, then SEQ for 3 cycles with `RESET_PC`=0 -> `cur_pc` = 0, 4, 8, 12. Assert `reset`=0 mid-run -> 0 on the next edge.
- `cur_pc`=0x100, BR, taken, `imm`=16'hFFFE -> 0xFC. Same with not taken -> 0x104. `pc_wre`=0 -> 0x100 holds.
- `cur_pc`=0x100, J with `jaddr`=0x40 -> 0x100. JR with `rs_val`=0x202 -> `TRAP_PC` and a single-cycle `misalign`. `trap` together with a valid BR -> `TRAP_PC`, no `misalign`.
- `link` at 0x10, 0x20, 0x30 (RAS pushes 0x14, 0x24, 0x34). JR+`ret` three times with `rs_val`=0 -> targets 0x34, 0x24, 0x14. A fourth JR+`ret` -> 0, `ras_underflow` pulses, `ras_empty`=1.
- Push 5 entries into a `RAS_DEPTH`=4 stack -> 4 pops return the newest 4; the oldest entry is lost and no underflow occurs until the 5th pop.
- Simultaneous `link`+`ret` with `cur_pc`=0x40 and top=0x80 -> next PC 0x80, top becomes 0x44, count unchanged. With `PC_RAS_EN` undefined -> JR always follows `rs_val`, `ras_empty`=1.

Source files
------------

// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter unit and its return-address stack.
//   pc_src_t        : next-PC source select (SEQ / BR / J / JR)
//   PC_INC          : sequential PC increment in bytes
//   TRAP_PC_DEFAULT : default redirect target for traps and misaligned targets
// -----------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ = 2'd0,
        PC_SRC_BR  = 2'd1,
        PC_SRC_J   = 2'd2,
        PC_SRC_JR  = 2'd3
    } pc_src_t;

    localparam int unsigned PC_INC          = 4;
    localparam logic [31:0] TRAP_PC_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras
// Circular return-address stack. The top pointer addresses the newest entry;
// the entry count saturates at RAS_DEPTH, so a push into a full stack
// silently overwrites the oldest entry.
//
// Ports:
//   clk          in  : clock, rising edge
//   reset        in  : synchronous active-low reset (clears count/pointer)
//   push_i       in  : push push_data_i (already qualified by the caller)
//   pop_i        in  : pop the top entry (already qualified by the caller)
//   push_data_i  in  : return address to push
//   top_o        out : newest entry (valid only when empty_o = 0)
//   empty_o      out : count is zero
//   underflow_o  out : registered one-cycle pulse after a pop on empty stack
//
// A simultaneous push and pop on a non-empty stack replaces the top entry in
// place. On an empty stack the pop underflows and the push proceeds normally.
// -----------------------------------------------------------------------------
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             underflow_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             underflow_q, underflow_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             empty;
    logic             do_pop;

    assign empty  = (count_q == '0);
    assign do_pop = pop_i & ~empty;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        top_d       = top_q;
        count_d     = count_q;
        underflow_d = pop_i & empty;
        wr_en       = 1'b0;
        wr_idx      = top_q;
        if (push_i && do_pop) begin
            // Return followed by a new call: overwrite the top in place.
            wr_en  = 1'b1;
            wr_idx = top_q;
        end else if (push_i) begin
            top_d  = top_q + 1'b1;
            wr_en  = 1'b1;
            wr_idx = top_q + 1'b1;
            if (count_q != FULL) begin
                count_d = count_q + 1'b1;
            end
        end else if (do_pop) begin
            top_d   = top_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            top_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            top_q       <= top_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset; the count alone decides validity, which keeps this a plain register file.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign top_o       = mem_q[top_q];
    assign empty_o     = empty;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
// Program-counter unit: owns the PC register and selects next-PC from the
// sequential, branch, jump and register-jump sources, with stall, trap
// redirect and misaligned-target trapping.
//
// Optional feature macro: PC_RAS_EN
//   defined   -> a return-address stack (pc_ras) serves JR returns
//   undefined -> no RAS; link/ret ignored, ras_empty = 1, ras_underflow = 0
//
// Ports:
//   clk            in  : clock, rising edge
//   reset          in  : synchronous active-low reset
//   pc_wre         in  : PC write enable (0 = stall)
//   pc_src         in  : next-PC source (SEQ=0, BR=1, J=2, JR=3)
//   branch_taken   in  : qualifies BR
//   imm            in  : branch offset in words
//   jaddr          in  : J-type target field
//   rs_val         in  : register jump target
//   link           in  : call; push pc_plus4 onto the RAS
//   ret            in  : JR is a return; pop the RAS
//   trap           in  : exception request
//   cur_pc         out : current PC (registered)
//   pc_plus4       out : cur_pc + 4 (combinational)
//   misalign       out : one-cycle pulse after a misaligned-target redirect
//   ras_empty      out : RAS holds no entries
//   ras_underflow  out : one-cycle pulse after a return on an empty RAS
// -----------------------------------------------------------------------------
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]      TRAP_PC   = TRAP_PC_DEFAULT,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_wre,
    input  logic [1:0]       pc_src,
    input  logic             branch_taken,
    input  logic [15:0]      imm,
    input  logic [25:0]      jaddr,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             link,
    input  logic             ret,
    input  logic             trap,
    output logic [WIDTH-1:0] cur_pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             misalign,
    output logic             ras_empty,
    output logic             ras_underflow
);

    localparam logic [WIDTH-1:0] TRAP_PC_EXT = WIDTH'(TRAP_PC);

    pc_src_t          src;
    logic [WIDTH-1:0] cur_pc_q, cur_pc_d;
    logic             misalign_q, misalign_d;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] j_target;
    logic [WIDTH-1:0] jr_target;
    logic [WIDTH-1:0] target;

    assign src       = pc_src_t'(pc_src);
    assign pc_plus4  = cur_pc_q + WIDTH'(PC_INC);
    assign br_offset = {{(WIDTH-18){imm[15]}}, imm, 2'b00};
    assign j_target  = {pc_plus4[WIDTH-1:28], jaddr, 2'b00};

`ifdef PC_RAS_EN
    logic             ras_op_en;
    logic             ras_push;
    logic             ras_pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty_w;
    logic             ras_underflow_w;

    // A stalled or trapping instruction must not disturb the stack.
    assign ras_op_en = pc_wre & ~trap;
    assign ras_push  = ras_op_en & link;
    assign ras_pop   = ras_op_en & ret & (src == PC_SRC_JR);

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_plus4),
        .top_o       (ras_top),
        .empty_o     (ras_empty_w),
        .underflow_o (ras_underflow_w)
    );

    assign jr_target     = (ret && !ras_empty_w) ? ras_top : rs_val;
    assign ras_empty     = ras_empty_w;
    assign ras_underflow = ras_underflow_w;
`else
    logic unused_ras;

    assign unused_ras    = link ^ ret;
    assign jr_target     = rs_val;
    assign ras_empty     = 1'b1;
    assign ras_underflow = 1'b0;
`endif

    always_comb begin
        target = pc_plus4;
        unique case (src)
            PC_SRC_SEQ: target = pc_plus4;
            PC_SRC_BR:  target = branch_taken ? (pc_plus4 + br_offset) : pc_plus4;
            PC_SRC_J:   target = j_target;
            PC_SRC_JR:  target = jr_target;
            default:    target = pc_plus4;
        endcase
    end

    // Trap outranks the misalign check; a stall holds the PC and clears the pulse.
    always_comb begin
        cur_pc_d   = cur_pc_q;
        misalign_d = 1'b0;
        if (pc_wre) begin
            if (trap) begin
                cur_pc_d = TRAP_PC_EXT;
            end else if (target[1:0] != 2'b00) begin
                cur_pc_d   = TRAP_PC_EXT;
                misalign_d = 1'b1;
            end else begin
                cur_pc_d = target;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_pc_q   <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            cur_pc_q   <= cur_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign cur_pc   = cur_pc_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_unit
// Self-checking bench for pc_unit. A behavioural model (plain arithmetic and a
// queue standing in for the return-address stack) predicts every cycle.
// Directed scenarios come first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_pc_unit;

    localparam int          W        = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP     = 32'h0000_0080;
    localparam int          DEPTH    = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pc_wre = 1'b0;
    logic [1:0]    pc_src = 2'd0;
    logic          branch_taken = 1'b0;
    logic [15:0]   imm = '0;
    logic [25:0]   jaddr = '0;
    logic [W-1:0]  rs_val = '0;
    logic          link = 1'b0;
    logic          ret = 1'b0;
    logic          trap = 1'b0;
    logic [W-1:0]  cur_pc;
    logic [W-1:0]  pc_plus4;
    logic          misalign;
    logic          ras_empty;
    logic          ras_underflow;

    pc_unit #(
        .WIDTH     (W),
        .RESET_PC  (RESET_PC),
        .TRAP_PC   (TRAP),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_wre        (pc_wre),
        .pc_src        (pc_src),
        .branch_taken  (branch_taken),
        .imm           (imm),
        .jaddr         (jaddr),
        .rs_val        (rs_val),
        .link          (link),
        .ret           (ret),
        .trap          (trap),
        .cur_pc        (cur_pc),
        .pc_plus4      (pc_plus4),
        .misalign      (misalign),
        .ras_empty     (ras_empty),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    bit          m_mis;
    bit          m_uf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of architectural behaviour, written from the rules directly.
    function automatic void model_step(input bit rst, input bit wre, input logic [1:0] src,
                                       input bit taken, input logic [15:0] im,
                                       input logic [25:0] ja, input logic [31:0] rs,
                                       input bit lnk, input bit rt, input bit tp);
        logic [31:0] pp4;
        logic [31:0] tgt;
        bit          pop;
        bit          push;
        pp4   = m_pc + 32'd4;
        m_mis = 1'b0;
        m_uf  = 1'b0;
        if (!rst) begin
            m_pc = RESET_PC;
            m_ras.delete();
            return;
        end
        if (!wre) return;
        pop  = RAS_EN && rt && (src == 2'd3) && !tp;
        push = RAS_EN && lnk && !tp;
        case (src)
            2'd0:    tgt = pp4;
            2'd1:    tgt = taken ? pp4 + 32'(int'($signed(im)) * 4) : pp4;
            2'd2:    tgt = {pp4[31:28], ja, 2'b00};
            default: tgt = (RAS_EN && rt && m_ras.size() > 0) ? m_ras[$] : rs;
        endcase
        // Pop then push gives "replace top" when both happen on a non-empty stack.
        if (pop) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            else m_uf = 1'b1;
        end
        if (push) begin
            m_ras.push_back(pp4);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        if (tp) m_pc = TRAP;
        else if (tgt[1:0] != 2'b00) begin
            m_pc  = TRAP;
            m_mis = 1'b1;
        end else m_pc = tgt;
    endfunction

    task automatic step(input string tag, input logic rst, input logic wre, input logic [1:0] src,
                        input logic taken, input logic [15:0] im, input logic [25:0] ja,
                        input logic [31:0] rs, input logic lnk, input logic rt, input logic tp);
        reset = rst; pc_wre = wre; pc_src = src; branch_taken = taken; imm = im;
        jaddr = ja; rs_val = rs; link = lnk; ret = rt; trap = tp;
        model_step(rst, wre, src, taken, im, ja, rs, lnk, rt, tp);
        @(posedge clk);
        #1;
        check({tag, ".cur_pc"},        cur_pc,        m_pc);
        check({tag, ".pc_plus4"},      pc_plus4,      m_pc + 32'd4);
        check({tag, ".misalign"},      misalign,      m_mis);
        check({tag, ".ras_underflow"}, ras_underflow, m_uf);
        check({tag, ".ras_empty"},     ras_empty,     (m_ras.size() == 0));
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b0, 1'b1, 2'd0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic seq(input string tag, input logic lnk);
        step(tag, 1'b1, 1'b1, 2'd0, 1'b0, '0, '0, '0, lnk, 1'b0, 1'b0);
    endtask
    task automatic jr(input string tag, input logic [31:0] rs, input logic lnk, input logic rt);
        step(tag, 1'b1, 1'b1, 2'd3, 1'b0, '0, '0, rs, lnk, rt, 1'b0);
    endtask
    task automatic br(input string tag, input logic taken, input logic [15:0] im, input logic tp);
        step(tag, 1'b1, 1'b1, 2'd1, taken, im, '0, '0, 1'b0, 1'b0, tp);
    endtask

    initial begin
        // Reset and sequential flow
        do_reset("reset");
        check("reset_pc_const", cur_pc, 32'h0);
        check("reset_empty_const", ras_empty, 1'b1);
        seq("seq1", 1'b0);
        seq("seq2", 1'b0);
        seq("seq3", 1'b0);
        check("seq3_const", cur_pc, 32'hC);
        do_reset("reset_mid");
        check("reset_mid_const", cur_pc, 32'h0);

        // Branches and stall
        jr("to_100a", 32'h100, 1'b0, 1'b0);
        br("br_taken", 1'b1, 16'hFFFE, 1'b0);
        check("br_taken_const", cur_pc, 32'hFC);
        jr("to_100b", 32'h100, 1'b0, 1'b0);
        br("br_not_taken", 1'b0, 16'hFFFE, 1'b0);
        check("br_not_taken_const", cur_pc, 32'h104);
        jr("to_100c", 32'h100, 1'b0, 1'b0);
        step("stall", 1'b1, 1'b0, 2'd1, 1'b1, 16'h0010, '0, '0, 1'b1, 1'b0, 1'b0);
        check("stall_const", cur_pc, 32'h100);

        // Jump, misaligned register jump, trap
        step("jump", 1'b1, 1'b1, 2'd2, 1'b0, '0, 26'h40, '0, 1'b0, 1'b0, 1'b0);
        check("jump_const", cur_pc, 32'h100);
        jr("jr_misalign", 32'h202, 1'b0, 1'b0);
        check("misalign_pc_const", cur_pc, TRAP);
        check("misalign_pulse_const", misalign, 1'b1);
        seq("after_misalign", 1'b0);
        check("misalign_clear_const", misalign, 1'b0);
        br("trap_br", 1'b1, 16'h0004, 1'b1);
        check("trap_pc_const", cur_pc, TRAP);
        check("trap_no_misalign_const", misalign, 1'b0);

        // Calls then returns
        jr("to_10", 32'h10, 1'b0, 1'b0);
        seq("link_10", 1'b1);
        jr("to_20", 32'h20, 1'b0, 1'b0);
        seq("link_20", 1'b1);
        jr("to_30", 32'h30, 1'b0, 1'b0);
        seq("link_30", 1'b1);
        jr("ret1", 32'h0, 1'b0, 1'b1);
        jr("ret2", 32'h0, 1'b0, 1'b1);
        jr("ret3", 32'h0, 1'b0, 1'b1);
        jr("ret_underflow", 32'h0, 1'b0, 1'b1);
        check("ret_underflow_pc_const", cur_pc, 32'h0);

        // Overflow: five pushes into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            jr("ovf_goto", 32'(i) * 32'h100, 1'b0, 1'b0);
            seq("ovf_link", 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            jr("ovf_ret", 32'h800, 1'b0, 1'b1);
        end

        // Simultaneous call and return
        jr("to_7c", 32'h7C, 1'b0, 1'b0);
        seq("link_7c", 1'b1);
        jr("to_40", 32'h40, 1'b0, 1'b0);
        jr("link_and_ret", 32'h0, 1'b1, 1'b1);
        jr("ret_after_swap", 32'h0, 1'b0, 1'b1);
        jr("ret_empty_again", 32'h8, 1'b0, 1'b1);

        // Randomized run against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] rs;
            rs = $urandom;
            if ($urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
            step("rand",
                 logic'($urandom_range(0, 49) != 0),
                 logic'($urandom_range(0, 9) != 0),
                 2'($urandom_range(0, 3)),
                 logic'($urandom_range(0, 1)),
                 16'($urandom),
                 26'($urandom),
                 rs,
                 logic'($urandom_range(0, 2) == 0),
                 logic'($urandom_range(0, 1) == 0),
                 logic'($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
